dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/core_config_pkg.sv | 52 +++++
 rtl/dmem_ram.sv | 41 ++++
 rtl/dmem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_config_pkg
// Purpose  : Shared core configuration: data width, default memory map,
//            MMIO register offsets, legal byte-enable patterns and the
//            address-region type used by the data-memory controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package core_config_pkg;

  localparam int XLEN   = 32;
  localparam int XBYTES = XLEN / 8;

  // Default memory map
  localparam logic [XLEN-1:0] DEF_DMEM_BASE  = 32'h0001_0000;
  localparam int              DEF_DMEM_WORDS = 1024;
  localparam logic [XLEN-1:0] DEF_MMIO_BASE  = 32'h0002_0000;
  localparam int              MMIO_BYTES     = 16;

  // MMIO register offsets within the 16-byte window
  localparam logic [3:0] MMIO_OFF_GPIO     = 4'h0;
  localparam logic [3:0] MMIO_OFF_CYCLE_LO = 4'h4;
  localparam logic [3:0] MMIO_OFF_CYCLE_HI = 4'h8;
  localparam logic [3:0] MMIO_OFF_RSVD     = 4'hC;

  // Legal byte-enable patterns: single bytes, aligned halves, full word
  localparam logic [XBYTES-1:0] BE_B0   = 4'b0001;
  localparam logic [XBYTES-1:0] BE_B1   = 4'b0010;
  localparam logic [XBYTES-1:0] BE_B2   = 4'b0100;
  localparam logic [XBYTES-1:0] BE_B3   = 4'b1000;
  localparam logic [XBYTES-1:0] BE_H0   = 4'b0011;
  localparam logic [XBYTES-1:0] BE_H1   = 4'b1100;
  localparam logic [XBYTES-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  function automatic logic be_legal(input logic [XBYTES-1:0] be);
    logic ok;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Purpose  : Synchronous single-port word RAM with per-byte write enables.
//            Read data is registered and reflects the word at addr before
//            any same-edge write (read-first).
// Ports    : clk    - clock
//            we     - write enable (gated per lane by byteen)
//            byteen - byte-lane enables
//            addr   - word index
//            wdata  - lane-aligned write data
//            rdata  - registered read word
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = 10,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [W/8-1:0]   byteen,
  input  logic [AW-1:0]    addr,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] r_mem [WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < W/8; i++) begin
      if (we && byteen[i]) begin
        r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Data-memory controller. Decodes each two-cycle load/store
//            request into the data RAM or a small MMIO window (GPIO output
//            register, 64-bit cycle counter with coherent LO/HI read),
//            executes it once on the edge ending its first cycle and drives
//            a registered response during the second cycle.
// Ports    : clk        - clock
//            rst_n      - synchronous active-low reset
//            mem_addr   - word-aligned byte address
//            mem_byteen - byte-lane enables
//            mem_we     - 1 = write, 0 = read
//            mem_req    - request, high two cycles per access
//            mem_wdata  - lane-aligned write data
//            mem_rdata  - full read word (second request cycle)
//            mem_err    - access fault (second request cycle)
//            gpio_out   - GPIO output register
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import core_config_pkg::*;
#(
  parameter logic [XLEN-1:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter int              DMEM_WORDS = DEF_DMEM_WORDS,
  parameter logic [XLEN-1:0] MMIO_BASE  = DEF_MMIO_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_byteen,
  input  logic              mem_we,
  input  logic              mem_req,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_err,
  output logic [XLEN-1:0]   gpio_out
);

  localparam int              c_aw        = $clog2(DMEM_WORDS);
  localparam logic [XLEN:0]   c_ram_bytes = (XLEN+1)'(DMEM_WORDS) << 2;
  localparam int              c_mmio_aw   = $clog2(MMIO_BYTES);

  logic              r_req_d;
  logic [63:0]       r_cycle;
  logic [31:0]       r_shadow;
  logic [XLEN-1:0]   r_gpio;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic              r_sel_ram;
  logic [c_aw-1:0]   r_idx;

  logic              w_new;
  logic [XLEN-1:0]   w_ram_off;
  logic [XLEN-1:0]   w_mmio_off;
  logic              w_ram_hit;
  logic              w_mmio_hit;
  region_e           w_region;
  logic              w_ro_wr;
  logic              w_err;
  logic              w_ok;
  logic [c_aw-1:0]   w_idx;
  logic [c_aw-1:0]   w_ram_addr;
  logic              w_ram_we;
  logic [XLEN-1:0]   w_ram_rdata;
  logic [XLEN-1:0]   w_mmio_rdata;

  // A new access is the first request cycle after an idle cycle.
  assign w_new = mem_req & ~r_req_d;

  // ---------------------------------------------------------------- decode
  assign w_ram_off  = mem_addr - DMEM_BASE;
  assign w_mmio_off = mem_addr - MMIO_BASE;
  assign w_ram_hit  = (mem_addr >= DMEM_BASE) && ({1'b0, w_ram_off} < c_ram_bytes);
  assign w_mmio_hit = (mem_addr >= MMIO_BASE) && (w_mmio_off[XLEN-1:c_mmio_aw] == '0);

  always_comb begin
    w_region = REGION_NONE;
    if (w_ram_hit) begin
      w_region = REGION_RAM;
    end else if (w_mmio_hit) begin
      w_region = REGION_MMIO;
    end
  end

  // Only GPIO_OUT is writable in the MMIO window.
  assign w_ro_wr = mem_we && (w_region == REGION_MMIO) && (w_mmio_off[3:0] != MMIO_OFF_GPIO);

  assign w_err = (w_region == REGION_NONE) || (mem_addr[1:0] != 2'b00)
               || !be_legal(mem_byteen) || w_ro_wr;
  assign w_ok  = ~w_err;

  assign w_idx = w_ram_off[c_aw+1:2];

  always_comb begin
    w_mmio_rdata = '0;
    case (w_mmio_off[3:0])
      MMIO_OFF_GPIO:     w_mmio_rdata = r_gpio;
      MMIO_OFF_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
      MMIO_OFF_CYCLE_HI: w_mmio_rdata = r_shadow;
      MMIO_OFF_RSVD:     w_mmio_rdata = '0;
      default:           w_mmio_rdata = '0;
    endcase
  end

  // -------------------------------------------------------------------- RAM
  // The RAM index is captured on the execute edge and replayed afterwards so
  // the registered read word stays put while mem_req is held, even if the
  // address bus moves.
  assign w_ram_addr = w_new ? w_idx : r_idx;
  assign w_ram_we   = w_new && rst_n && w_ok && (w_region == REGION_RAM) && mem_we;

  dmem_ram #(
    .WORDS (DMEM_WORDS),
    .AW    (c_aw),
    .W     (XLEN)
  ) u_ram (
    .clk    (clk),
    .we     (w_ram_we),
    .byteen (mem_byteen),
    .addr   (w_ram_addr),
    .wdata  (mem_wdata),
    .rdata  (w_ram_rdata)
  );

  // ---------------------------------------------------- state and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_d   <= 1'b0;
      r_cycle   <= '0;
      r_shadow  <= '0;
      r_gpio    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_sel_ram <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_req_d <= mem_req;
      r_cycle <= r_cycle + 64'd1;

      if (w_new) begin
        r_idx     <= w_idx;
        r_err     <= w_err;
        r_sel_ram <= w_ok && (w_region == REGION_RAM) && !mem_we;
        r_rdata   <= (w_ok && (w_region == REGION_MMIO) && !mem_we) ? w_mmio_rdata : '0;

        // LO read latches the upper half so a following HI read is coherent.
        if (w_ok && (w_region == REGION_MMIO) && !mem_we
            && (w_mmio_off[3:0] == MMIO_OFF_CYCLE_LO)) begin
          r_shadow <= r_cycle[63:32];
        end

        if (w_ok && (w_region == REGION_MMIO) && mem_we) begin
          for (int i = 0; i < XLEN/8; i++) begin
            if (mem_byteen[i]) begin
              r_gpio[i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
          end
        end
      end else if (!mem_req) begin
        r_rdata   <= '0;
        r_err     <= 1'b0;
        r_sel_ram <= 1'b0;
      end
    end
  end

  assign mem_rdata = r_sel_ram ? w_ram_rdata : r_rdata;
  assign mem_err   = r_err;
  assign gpio_out  = r_gpio;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Self-checking bench for dmem_ctrl. A memory-map level model
//            predicts the response of every access; a compare process
//            checks the DUT against it each cycle, and directed accesses
//            carry hand-computed literal expectations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic        mem_we;
  logic        mem_req;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] gpio_out;

  int total = 0;
  int bad   = 0;

  dmem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .gpio_out   (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [31:0] m_ram  [int unsigned];
  bit          m_full [int unsigned];
  logic [63:0] m_cnt;
  bit          m_cnt_ok;
  logic [31:0] m_shadow;
  bit          m_shadow_ok;
  logic [31:0] m_gpio;
  bit          m_prev;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          exp_known;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_cnt_ok = 1; m_shadow = 0; m_shadow_ok = 1;
      m_gpio = 0; m_prev = 0;
      exp_rdata = 0; exp_err = 0; exp_known = 1;
      check_en = 1'b1;
    end else begin
      if (mem_req && !m_prev) begin
        bit          in_ram, in_mmio, legal_be, err;
        int unsigned idx;
        in_ram   = (mem_addr >= 32'h0001_0000) && (mem_addr < 32'h0001_1000);
        in_mmio  = (mem_addr >= 32'h0002_0000) && (mem_addr < 32'h0002_0010);
        legal_be = mem_byteen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0011, 4'b1100, 4'b1111};
        err = (!in_ram && !in_mmio) || (mem_addr % 4 != 0) || !legal_be
              || (in_mmio && mem_we && mem_addr != 32'h0002_0000);
        idx = (mem_addr - 32'h0001_0000) / 4;
        exp_rdata = 0; exp_err = err; exp_known = 1;
        if (!err && mem_we) begin
          if (in_ram) begin
            if (!m_ram.exists(idx)) m_ram[idx] = 0;
            for (int b = 0; b < 4; b++)
              if (mem_byteen[b]) m_ram[idx][b*8 +: 8] = mem_wdata[b*8 +: 8];
            if (mem_byteen == 4'b1111) m_full[idx] = 1;
          end else begin
            for (int b = 0; b < 4; b++)
              if (mem_byteen[b]) m_gpio[b*8 +: 8] = mem_wdata[b*8 +: 8];
          end
        end else if (!err) begin
          if (in_ram) begin
            exp_known = m_full.exists(idx);
            exp_rdata = exp_known ? m_ram[idx] : 32'h0;
          end else begin
            case (mem_addr - 32'h0002_0000)
              0: exp_rdata = m_gpio;
              4: begin
                exp_rdata   = m_cnt[31:0];
                exp_known   = m_cnt_ok;
                m_shadow    = m_cnt[63:32];
                m_shadow_ok = m_cnt_ok;
              end
              8: begin
                exp_rdata = m_shadow;
                exp_known = m_shadow_ok;
              end
              default: exp_rdata = 0;
            endcase
          end
        end
      end else if (!mem_req) begin
        exp_rdata = 0; exp_err = 0; exp_known = 1;
      end
      m_cnt  = m_cnt + 1;
      m_prev = mem_req;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      if (exp_known) chk("model_rdata", mem_rdata, exp_rdata);
      chk("model_err", {31'b0, mem_err}, {31'b0, exp_err});
      chk("model_gpio", gpio_out, m_gpio);
    end
  end

  // --------------------------------------------------------------- stimulus
  // Called at a negedge; returns at a negedge after one idle cycle.
  task automatic acc(input bit we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] wd2,
                     output logic [31:0] rd, output logic er);
    mem_req = 1; mem_we = we; mem_addr = a; mem_byteen = be; mem_wdata = wd;
    @(negedge clk);
    rd = mem_rdata; er = mem_err;
    mem_wdata = wd2;
    @(negedge clk);
    mem_req = 0; mem_we = 0; mem_wdata = 0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_byteen = 0; mem_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_err", {31'b0, mem_err}, 32'h0);
    chk("reset_gpio", gpio_out, 32'h0);

    // First access right after reset: counter was 0 at the execute edge
    rst_n = 1;
    acc(0, 32'h0002_0004, 4'hF, 0, 0, rd, er);
    chk("cycle_lo_first", rd, 32'h0);

    // Full-word write and read back
    acc(1, 32'h0001_0010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, rd, er);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", {31'b0, er}, 32'h0);
    acc(0, 32'h0001_0010, 4'hF, 0, 0, rd, er);
    chk("rd_full", rd, 32'hDEADBEEF);
    chk("rd_full_err", {31'b0, er}, 32'h0);

    // Single-lane merge
    acc(1, 32'h0001_0010, 4'b0010, 32'h0000AA00, 32'h0000AA00, rd, er);
    acc(0, 32'h0001_0010, 4'b0001, 0, 0, rd, er);
    chk("rd_merge", rd, 32'hDEADAAEF);

    // Faults
    acc(0, 32'h0003_0000, 4'hF, 0, 0, rd, er);
    chk("unmapped_err", {31'b0, er}, 32'h1);
    chk("unmapped_rdata", rd, 32'h0);
    acc(1, 32'h0001_0010, 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, er);
    chk("badbe_err", {31'b0, er}, 32'h1);
    acc(0, 32'h0001_0012, 4'b0011, 0, 0, rd, er);
    chk("misalign_err", {31'b0, er}, 32'h1);
    acc(0, 32'h0001_1000, 4'hF, 0, 0, rd, er);
    chk("ram_end_err", {31'b0, er}, 32'h1);
    acc(0, 32'h0002_0010, 4'hF, 0, 0, rd, er);
    chk("mmio_end_err", {31'b0, er}, 32'h1);
    acc(1, 32'h0002_0004, 4'hF, 32'h5, 32'h5, rd, er);
    chk("ro_wr_err", {31'b0, er}, 32'h1);
    acc(1, 32'h0002_000C, 4'hF, 32'h5, 32'h5, rd, er);
    chk("rsvd_wr_err", {31'b0, er}, 32'h1);
    acc(0, 32'h0002_000C, 4'hF, 0, 0, rd, er);
    chk("rsvd_rd", rd, 32'h0);
    chk("rsvd_rd_err", {31'b0, er}, 32'h0);
    acc(0, 32'h0001_0010, 4'hF, 0, 0, rd, er);
    chk("ram_unchanged", rd, 32'hDEADAAEF);

    // Last RAM word
    acc(1, 32'h0001_0FFC, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, rd, er);
    acc(0, 32'h0001_0FFC, 4'hF, 0, 0, rd, er);
    chk("ram_last", rd, 32'hCAFEF00D);

    // GPIO: single execution despite wdata change in the second cycle
    acc(1, 32'h0002_0000, 4'hF, 32'h1, 32'h2, rd, er);
    chk("gpio_once", gpio_out, 32'h1);
    acc(1, 32'h0002_0000, 4'b1100, 32'hAB00_0000, 32'hAB00_0000, rd, er);
    chk("gpio_lane", gpio_out, 32'hAB00_0001);
    acc(0, 32'h0002_0000, 4'hF, 0, 0, rd, er);
    chk("gpio_rd", rd, 32'hAB00_0001);

    // Request held four cycles with the address moving: response held
    mem_req = 1; mem_we = 0; mem_addr = 32'h0001_0010; mem_byteen = 4'hF;
    @(negedge clk);
    chk("hold_0", mem_rdata, 32'hDEADAAEF);
    mem_addr = 32'h0001_0FFC;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("hold_n", mem_rdata, 32'hDEADAAEF);
    end
    mem_req = 0;
    @(negedge clk);
    chk("idle_rdata", mem_rdata, 32'h0);

    // Coherent LO/HI across a 32-bit carry
    m_cnt_ok = 0;
    force dut.r_cycle = 64'h0000_0001_FFFF_FFFF;
    mem_req = 1; mem_we = 0; mem_addr = 32'h0002_0004; mem_byteen = 4'hF;
    @(negedge clk);
    chk("cycle_lo", mem_rdata, 32'hFFFF_FFFF);
    release dut.r_cycle;
    @(negedge clk);
    mem_req = 0;
    repeat (2) @(negedge clk);
    acc(0, 32'h0002_0008, 4'hF, 0, 0, rd, er);
    chk("cycle_hi", rd, 32'h1);

    // Reset during the first cycle of a RAM write cancels it
    acc(1, 32'h0001_0020, 4'hF, 32'h1122_3344, 32'h1122_3344, rd, er);
    rst_n = 0; mem_req = 1; mem_we = 1; mem_addr = 32'h0001_0020;
    mem_byteen = 4'hF; mem_wdata = 32'h5566_7788;
    @(negedge clk);
    chk("rst_req_rdata", mem_rdata, 32'h0);
    chk("rst_req_err", {31'b0, mem_err}, 32'h0);
    chk("rst_req_gpio", gpio_out, 32'h0);
    rst_n = 1; mem_req = 0; mem_we = 0; mem_wdata = 0;
    @(negedge clk);
    acc(0, 32'h0001_0020, 4'hF, 0, 0, rd, er);
    chk("rst_no_write", rd, 32'h1122_3344);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
